// File: rtl/cast_output_controller_pkg.sv
// Shared definitions for the cast router output-port controller.
//   CN                 number of input ports competing for one output
//   PTR_W              width of the round-robin pointer
//   CREDIT_W           width of the exported credit counter
//   CAST_CREDIT_ALLOC  default downstream buffer depth (flits)
//   flit_type_e        flit type encoding carried on out_flit_type
//   oc_state_e         output-port lock state
package cast_output_controller_pkg;

  localparam int CN                         = 5;
  localparam int PTR_W                      = (CN > 1) ? $clog2(CN) : 1;
  localparam int CREDIT_W                   = 32;
  localparam int unsigned CAST_CREDIT_ALLOC = 8;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } oc_state_e;

endpackage

// File: rtl/cast_output_controller_credit_counter.sv
// Downstream credit counter, shared by the output controllers and the local
// ejection path. Counts free slots in the downstream buffer, clamped to
// [0, CREDIT_ALLOC]; an over- or under-run is absorbed and latched in err_o.
//   clk    clock
//   rstn   asynchronous active-low reset (counter returns to CREDIT_ALLOC)
//   inc_i  downstream freed one slot (+1)
//   dec_i  one flit sent downstream (-1)
//   cnt_o  current credit count
//   err_o  sticky over/underflow flag
module cast_credit_counter
  import cast_output_controller_pkg::*;
#(
  parameter int unsigned CREDIT_ALLOC = CAST_CREDIT_ALLOC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CREDIT_W-1:0] cnt_o,
  output logic                err_o
);

  localparam logic [CREDIT_W-1:0] MAX_CNT = CREDIT_W'(CREDIT_ALLOC);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    err_d = err_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == MAX_CNT) err_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      // Simultaneous +1/-1 nets to zero, including at either bound.
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= MAX_CNT;
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/cast_output_controller.sv
// Output-port controller of the cast router. Arbitrates the per-input head
// requests round-robin, issues a one-hot grant pulse, locks the crossbar
// select to the winner until its TAIL flit departs, and tracks downstream
// credits for the input controllers' flow-control check.
//   clk            clock
//   rstn           asynchronous active-low reset
//   req_in         per-input head requests (multi-hot)
//   grant          one-hot grant pulse, combinational, IDLE only
//   granted        |grant
//   owner          one-hot crossbar select while locked, 0 when idle
//   out_fire       a flit leaves this output this cycle
//   out_flit_type  type of the departing flit
//   credit_upd     downstream freed one slot
//   credit_cnt     current credits, 0..CREDIT_ALLOC
//   can_send       owner!=0 && credit_cnt!=0
//   err            sticky protocol / credit error flag
module cast_output_controller
  import cast_output_controller_pkg::*;
#(
  parameter int          x_pos        = 0,
  parameter int          y_pos        = 0,
  parameter int unsigned CREDIT_ALLOC = CAST_CREDIT_ALLOC
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CN-1:0]       req_in,
  output logic [CN-1:0]       grant,
  output logic                granted,
  output logic [CN-1:0]       owner,
  input  logic                out_fire,
  input  logic [1:0]          out_flit_type,
  input  logic                credit_upd,
  output logic [CREDIT_W-1:0] credit_cnt,
  output logic                can_send,
  output logic                err
);

  // Coordinates only name the instance; reject nonsense at elaboration.
  if (CREDIT_ALLOC == 0 || x_pos < 0 || y_pos < 0) begin : g_bad_param
    $error("cast_output_controller: CREDIT_ALLOC must be >0 and coordinates non-negative");
  end

  oc_state_e        state_q, state_d;
  logic [CN-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             first_q, first_d;   // next fire is the packet's first flit
  logic             perr_q, perr_d;
  logic             fire_ok;            // accepted fire, consumes one credit
  logic             credit_err;

  // Round-robin pick: first requester at or after the pointer, cyclically.
  logic [CN-1:0]    pick;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             pick_found;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    scan_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < CN; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % CN);
      if (!pick_found && req_in[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    if (pick_found) pick[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    perr_d  = perr_q;
    grant   = '0;
    fire_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Nothing owns the port, so a departing flit is a protocol error
        // and is not charged against credits.
        if (out_fire) perr_d = 1'b1;
        if (pick_found && credit_cnt != '0) begin
          grant   = pick;
          owner_d = pick;
          state_d = ST_LOCKED;
          first_d = 1'b1;
          ptr_d   = (pick_idx == PTR_W'(CN - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (out_fire) begin
          if (!first_q && out_flit_type == FLIT_HEAD) begin
            // A second HEAD inside a packet is dropped from all state.
            perr_d = 1'b1;
          end else begin
            fire_ok = 1'b1;
            first_d = 1'b0;
            // No grant this cycle: the next winner appears one cycle later.
            if (out_flit_type == FLIT_TAIL) begin
              state_d = ST_IDLE;
              owner_d = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      perr_q  <= perr_d;
    end
  end

  cast_credit_counter #(
    .CREDIT_ALLOC (CREDIT_ALLOC)
  ) u_credit (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (credit_upd),
    .dec_i (fire_ok),
    .cnt_o (credit_cnt),
    .err_o (credit_err)
  );

  assign granted  = |grant;
  assign owner    = owner_q;
  assign can_send = (owner_q != '0) && (credit_cnt != '0);
  assign err      = perr_q | credit_err;

endmodule

// File: tb/tb_cast_output_controller.sv
// Self-checking bench for cast_output_controller: directed scenarios followed
// by randomized bursts, every cycle compared against a packet-level model.
module tb_cast_output_controller;
  import cast_output_controller_pkg::*;

  localparam int ALLOC = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CN-1:0] req_in;
  logic [CN-1:0] grant;
  logic          granted;
  logic [CN-1:0] owner;
  logic          out_fire;
  logic [1:0]    out_flit_type;
  logic          credit_upd;
  logic [31:0]   credit_cnt;
  logic          can_send;
  logic          err;

  always #5 clk = ~clk;

  cast_output_controller #(
    .x_pos        (0),
    .y_pos        (0),
    .CREDIT_ALLOC (ALLOC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_in        (req_in),
    .grant         (grant),
    .granted       (granted),
    .owner         (owner),
    .out_fire      (out_fire),
    .out_flit_type (out_flit_type),
    .credit_upd    (credit_upd),
    .credit_cnt    (credit_cnt),
    .can_send      (can_send),
    .err           (err)
  );

  int errors = 0;
  int checks = 0;

  // Packet-level model: owner is an input index (-1 = port free).
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_err;
  bit m_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = ALLOC;
    m_err   = 1'b0;
    m_first = 1'b0;
  endfunction

  // Winner index this cycle, or -1 when nothing may be granted.
  function automatic int model_pick();
    if (m_owner >= 0 || m_cnt == 0) return -1;
    for (int i = 0; i < CN; i++) begin
      int idx = (m_ptr + i) % CN;
      if (req_in[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int g  = model_pick();
    bit ok = 1'b0;
    if (m_owner < 0) begin
      if (out_fire) m_err = 1'b1;
      if (g >= 0) begin
        m_owner = g;
        m_ptr   = (g + 1) % CN;
        m_first = 1'b1;
      end
    end else if (out_fire) begin
      if (!m_first && out_flit_type == FLIT_HEAD) begin
        m_err = 1'b1;
      end else begin
        ok      = 1'b1;
        m_first = 1'b0;
        if (out_flit_type == FLIT_TAIL) m_owner = -1;
      end
    end
    if (ok && !credit_upd) begin
      if (m_cnt == 0) m_err = 1'b1;
      else            m_cnt = m_cnt - 1;
    end else if (credit_upd && !ok) begin
      if (m_cnt == ALLOC) m_err = 1'b1;
      else                m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic compare_all(input string tag);
    int g = model_pick();
    check({tag, ".grant"},    32'(grant),      onehot(g));
    check({tag, ".granted"},  32'(granted),    32'(g >= 0));
    check({tag, ".owner"},    32'(owner),      onehot(m_owner));
    check({tag, ".credit"},   credit_cnt,      32'(m_cnt));
    check({tag, ".can_send"}, 32'(can_send),   32'(m_owner >= 0 && m_cnt != 0));
    check({tag, ".err"},      32'(err),        32'(m_err));
  endtask

  // Apply inputs mid-cycle and compare; tick() then commits the clock edge.
  task automatic drive(input logic [CN-1:0] r, input bit f, input logic [1:0] ft,
                       input bit u, input string tag);
    @(negedge clk);
    req_in        = r;
    out_fire      = f;
    out_flit_type = ft;
    credit_upd    = u;
    #1;
    compare_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic [CN-1:0] r, input bit f, input logic [1:0] ft,
                     input bit u, input string tag);
    drive(r, f, ft, u, tag);
    tick();
  endtask

  task automatic reset_assert(input string tag);
    @(negedge clk);
    #2;
    rstn       = 1'b0;
    req_in     = '0;
    out_fire   = 1'b0;
    credit_upd = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
  endtask

  task automatic reset_release();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CN-1:0] r;
    logic [1:0]    ft;
    bit            f;
    bit            u;
    int            k;

    rstn          = 1'b0;
    req_in        = '0;
    out_fire      = 1'b0;
    out_flit_type = FLIT_BODY;
    credit_upd    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Reset values.
    drive('0, 0, FLIT_BODY, 0, "reset");
    check("rst_credit", credit_cnt, 32'd8);
    check("rst_owner",  32'(owner), 32'd0);
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_err",    32'(err),   32'd0);
    tick();

    // Round-robin from pointer 0, then a 4-flit packet.
    drive(5'b10100, 0, FLIT_HEAD, 0, "arb0");
    check("rr_first_grant", 32'(grant), 32'b00100);
    tick();
    cyc(5'b10100, 1, FLIT_HEAD, 0, "p0_head");
    cyc(5'b10100, 1, FLIT_BODY, 0, "p0_body1");
    cyc(5'b10100, 1, FLIT_BODY, 0, "p0_body2");
    drive(5'b10100, 1, FLIT_TAIL, 0, "p0_tail");
    check("no_grant_on_tail", 32'(grant), 32'd0);
    tick();
    drive(5'b10100, 0, FLIT_HEAD, 0, "arb1");
    check("owner_cleared", 32'(owner), 32'd0);
    check("credit_after_pkt", credit_cnt, 32'd4);
    check("rr_second_grant", 32'(grant), 32'b10000);
    tick();

    // Fire and credit together at 3, then overflow at full.
    cyc('0, 1, FLIT_HEAD, 0, "p1_head");
    cyc('0, 1, FLIT_BODY, 1, "p1_both");
    drive('0, 1, FLIT_TAIL, 0, "p1_tail");
    check("both_keeps_count", credit_cnt, 32'd3);
    tick();
    repeat (6) cyc('0, 0, FLIT_BODY, 1, "refill");
    drive('0, 0, FLIT_BODY, 1, "overflow");
    check("full_credit", credit_cnt, 32'd8);
    tick();
    drive('0, 0, FLIT_BODY, 0, "after_ovf");
    check("ovf_saturates", credit_cnt, 32'd8);
    check("ovf_err", 32'(err), 32'd1);
    tick();

    // Drain to zero with a pending request: grant waits for a credit.
    drive(5'b00001, 0, FLIT_HEAD, 0, "p2_arb");
    check("p2_grant", 32'(grant), 32'b00001);
    tick();
    cyc(5'b00001, 1, FLIT_HEAD, 0, "p2_head");
    repeat (6) cyc(5'b00001, 1, FLIT_BODY, 0, "p2_body");
    cyc(5'b00001, 1, FLIT_TAIL, 0, "p2_tail");
    drive(5'b00001, 0, FLIT_BODY, 0, "starved");
    check("starved_credit", credit_cnt, 32'd0);
    check("starved_grant",  32'(grant), 32'd0);
    tick();
    drive(5'b00001, 0, FLIT_BODY, 1, "starved_upd");
    check("upd_cycle_grant", 32'(grant), 32'd0);
    tick();
    drive(5'b00001, 0, FLIT_BODY, 0, "credit_back");
    check("credit_back_cnt",   credit_cnt, 32'd1);
    check("credit_back_grant", 32'(grant), 32'b00001);
    tick();

    // Lock input 3 with two credits, then reset mid-packet.
    cyc('0, 1, FLIT_TAIL, 0, "p3_tail");
    cyc('0, 0, FLIT_BODY, 1, "p4_upd1");
    cyc('0, 0, FLIT_BODY, 1, "p4_upd2");
    drive(5'b01000, 0, FLIT_HEAD, 0, "p4_arb");
    check("p4_grant", 32'(grant), 32'b01000);
    tick();
    cyc('0, 1, FLIT_HEAD, 1, "p4_head");
    drive('0, 0, FLIT_BODY, 0, "mid_pkt");
    check("mid_owner",  32'(owner), 32'b01000);
    check("mid_credit", credit_cnt, 32'd2);
    tick();
    reset_assert("mid_reset");
    check("mid_rst_owner",  32'(owner), 32'd0);
    check("mid_rst_credit", credit_cnt, 32'd8);
    check("mid_rst_err",    32'(err),   32'd0);
    reset_release();
    drive(5'b00010, 0, FLIT_HEAD, 0, "post_rst_arb");
    check("post_rst_grant", 32'(grant), 32'b00010);
    tick();

    // Duplicate HEAD inside a packet is an error and is not charged.
    cyc('0, 1, FLIT_HEAD, 0, "p5_head");
    cyc('0, 1, FLIT_HEAD, 0, "p5_dup_head");
    drive('0, 0, FLIT_BODY, 0, "after_dup");
    check("dup_err",    32'(err),   32'd1);
    check("dup_credit", credit_cnt, 32'd7);
    check("dup_owner",  32'(owner), 32'b00010);
    tick();
    cyc('0, 1, FLIT_TAIL, 0, "p5_tail");

    // Fire while idle.
    reset_assert("idle_rst");
    reset_release();
    cyc('0, 1, FLIT_BODY, 0, "idle_fire");
    drive('0, 0, FLIT_BODY, 0, "after_idle_fire");
    check("idle_fire_err",    32'(err),   32'd1);
    check("idle_fire_credit", credit_cnt, 32'd8);
    tick();

    // Randomized bursts, each from a fresh reset.
    for (int b = 0; b < 4; b++) begin
      reset_assert("rnd_rst");
      reset_release();
      for (int i = 0; i < 150; i++) begin
        r  = CN'($urandom);
        f  = (m_owner >= 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
        k  = $urandom_range(0, 9);
        ft = (k == 0) ? FLIT_HEAD : (k < 7) ? FLIT_BODY : FLIT_TAIL;
        if (m_first && k < 5) ft = FLIT_HEAD;
        u  = ($urandom_range(0, 2) == 0);
        cyc(r, f, ft, u, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
